serial_transmitter: RTL

Asynchronous-serial transmitter, the sending end of the team's serial link; pairs with `serial_receiver` over a single line. Accepts one byte from a producer via the `dav_`/`rfd` handshake and emits a frame on `txd`: start bit, 8 data bits LSB first, then stop bit(s), each bit lasting a fixed number of clocks. Sits between a byte producer and the physical line.

---
 rtl/serial_transmitter_if.sv | 34 +++
 rtl/serial_transmitter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serial_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_transmitter_if
// Purpose  : Byte handshake and serial line bundle between a byte producer
//            and serial_transmitter.
// Signals  : dav_    - data available, active low (producer -> transmitter)
//            tx_byte - byte to send, sampled at the acceptance edge
//            rfd     - ready for data, active high (transmitter -> producer)
//            txd     - serial line output, registered
// Revision : 1.0 - initial release
// ============================================================================
interface serial_transmitter_if;
  logic       dav_;
  logic [7:0] tx_byte;
  logic       rfd;
  logic       txd;

  // Producer side.
  modport master (
    output dav_,
    output tx_byte,
    input  rfd,
    input  txd
  );

  // Transmitter side.
  modport slave (
    input  dav_,
    input  tx_byte,
    output rfd,
    output txd
  );
endinterface
`default_nettype wire

// File: rtl/serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : serial_transmitter
// Purpose  : Asynchronous-serial transmitter. Accepts one byte over the
//            dav_/rfd handshake and sends start bit, 8 data bits LSB first
//            and STOP_BITS stop bits on txd, each bit BIT_TIME clocks long.
// Ports    : clock  - single clock, rising edge
//            reset_ - asynchronous active-low reset
//            bus    - serial_transmitter_if.slave (dav_, tx_byte, rfd, txd)
// Params   : BIT_TIME  - clocks per bit, 2..31
//            STOP_BITS - 1 or 2
//            START_BIT - start bit level; idle/stop level is its complement
// Revision : 1.0 - initial release
// ============================================================================
module serial_transmitter #(
  parameter int   BIT_TIME  = 16,
  parameter int   STOP_BITS = 1,
  parameter logic START_BIT = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_,
  serial_transmitter_if.slave   bus
);

  localparam logic       c_IDLE_LEVEL = ~START_BIT;
  localparam logic [5:0] c_BIT_WAIT   = 6'(BIT_TIME);
  localparam logic [5:0] c_STOP_WAIT  = 6'(BIT_TIME * STOP_BITS);

  // START and DATA share one state: the start bit is simply the first
  // BIT_TIME interval before the first shift.
  localparam logic [1:0] c_ST_IDLE      = 2'd0;
  localparam logic [1:0] c_ST_DATA      = 2'd1;
  localparam logic [1:0] c_ST_STOP      = 2'd2;
  localparam logic [1:0] c_ST_HANDSHAKE = 2'd3;

  logic [1:0] r_state,  w_state_next;
  logic [7:0] r_buffer, w_buffer_next;
  logic [3:0] r_count,  w_count_next;
  logic [5:0] r_wait,   w_wait_next;
  logic       r_txd,    w_txd_next;
  logic       r_rfd,    w_rfd_next;
  logic       w_wait_done;

  assign w_wait_done = (r_wait == 6'd1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state  <= c_ST_IDLE;
      r_buffer <= 8'd0;
      r_count  <= 4'd0;
      r_wait   <= 6'd0;
      r_txd    <= c_IDLE_LEVEL;
      r_rfd    <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_buffer <= w_buffer_next;
      r_count  <= w_count_next;
      r_wait   <= w_wait_next;
      r_txd    <= w_txd_next;
      r_rfd    <= w_rfd_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (!bus.dav_) w_state_next = c_ST_DATA;
      end
      c_ST_DATA: begin
        // r_count reaches 0 once the 8th data bit has been launched; the
        // next wait expiry ends that bit.
        if (w_wait_done && (r_count == 4'd0)) w_state_next = c_ST_STOP;
      end
      c_ST_STOP: begin
        // dav_ is already looked at on the last stop edge so rfd can rise
        // exactly at the end of the stop interval.
        if (w_wait_done) begin
          w_state_next = bus.dav_ ? c_ST_IDLE : c_ST_HANDSHAKE;
        end
      end
      c_ST_HANDSHAKE: begin
        if (bus.dav_) w_state_next = c_ST_IDLE;
      end
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output and datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    w_buffer_next = r_buffer;
    w_count_next  = r_count;
    w_wait_next   = r_wait;
    w_txd_next    = r_txd;
    w_rfd_next    = r_rfd;
    case (r_state)
      c_ST_IDLE: begin
        w_txd_next = c_IDLE_LEVEL;
        w_rfd_next = 1'b1;
        if (!bus.dav_) begin
          w_buffer_next = bus.tx_byte;
          w_rfd_next    = 1'b0;
          w_txd_next    = START_BIT;
          w_count_next  = 4'd8;
          w_wait_next   = c_BIT_WAIT;
        end
      end
      c_ST_DATA: begin
        if (w_wait_done) begin
          if (r_count == 4'd0) begin
            w_txd_next  = c_IDLE_LEVEL;
            w_wait_next = c_STOP_WAIT;
          end else begin
            w_txd_next    = r_buffer[0];
            w_buffer_next = {1'b0, r_buffer[7:1]};
            w_count_next  = r_count - 4'd1;
            w_wait_next   = c_BIT_WAIT;
          end
        end else begin
          w_wait_next = r_wait - 6'd1;
        end
      end
      c_ST_STOP: begin
        w_txd_next = c_IDLE_LEVEL;
        if (w_wait_done) begin
          if (bus.dav_) w_rfd_next = 1'b1;
        end else begin
          w_wait_next = r_wait - 6'd1;
        end
      end
      c_ST_HANDSHAKE: begin
        w_txd_next = c_IDLE_LEVEL;
        if (bus.dav_) w_rfd_next = 1'b1;
      end
      default: begin
        w_txd_next = c_IDLE_LEVEL;
        w_rfd_next = 1'b1;
      end
    endcase
  end

  assign bus.txd = r_txd;
  assign bus.rfd = r_rfd;

endmodule
`default_nettype wire
